adc_spi_controller: RTL and testbench

SPI master that sequences the two-channel 16-bit serial ADC used by the audio front end. It drives CS_/SCK/SDI, issues channel-select commands and retires one conversion per frame at a fixed sample rate. Each returned word is tagged with the channel commanded in the previous frame, because the ADC's channel select is pipelined by one frame. Samples are presented to the downstream DSP datapath over a valid/ready interface.

---
 rtl/adc_spi_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_adc_spi_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_controller.sv
// -----------------------------------------------------------------------------
// adc_spi_controller
//
// SPI master for the two-channel 16-bit serial ADC of the audio front end.
// Each frame drops CS_, shifts a 16-bit channel-select command out on SDI
// while shifting the previous conversion in from SDO, then raises CS_ and
// waits for the frame timer. The ADC's channel select is pipelined by one
// frame, so each returned word is tagged with the channel commanded in the
// previous frame. The first frame of every session is a dummy and is not
// delivered.
//
// Parameters:
//   CLK_DIV        CLK cycles per SCK half-period (>=1)
//   CS_SETUP       CLK cycles from CS_ fall to first SCK rise (>=1)
//   SAMPLE_PERIOD  CLK cycles between frame starts; raised to at least
//                  CS_SETUP+32*CLK_DIV+2 so CS_ idles high >= 2 cycles
//
// Ports:
//   CLK, RESET_        clock (rising edge), asynchronous active-low reset
//   enable, chan_en    run request, channel enables (bit0 left, bit1 right)
//   CS_, SCK, SDI, SDO SPI bus to the ADC (SCK idles low, MSB first)
//   sample_data/chan   held sample and its channel (0 left, 1 right)
//   sample_valid/ready single-entry valid/ready output buffer
//   overrun, overrun_clr sticky overwrite flag and its clear (set wins)
//
// Build option:
//   ADC_SIGN_CONVERT_EN  when defined, offset-binary ADC words are converted
//                        to signed 1.15 by inverting the MSB; otherwise the
//                        raw word is passed through.
// -----------------------------------------------------------------------------
module adc_spi_controller #(
    parameter int CLK_DIV       = 4,
    parameter int CS_SETUP      = 2,
    parameter int SAMPLE_PERIOD = 1250
) (
    input  logic               CLK,
    input  logic               RESET_,
    input  logic               enable,
    input  logic [1:0]         chan_en,
    output logic               CS_,
    output logic               SCK,
    output logic               SDI,
    input  logic               SDO,
    output logic signed [15:0] sample_data,
    output logic               sample_chan,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               overrun,
    input  logic               overrun_clr
);

    localparam int FRAME_LOW = CS_SETUP + 32 * CLK_DIV;
    localparam int PERIOD    = (SAMPLE_PERIOD > FRAME_LOW + 2) ? SAMPLE_PERIOD : FRAME_LOW + 2;
    localparam int TMR_W     = $clog2(PERIOD);
    localparam int DIV_MAX   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int DIV_W     = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(PERIOD - 1);
    localparam logic [DIV_W-1:0] SETUP_LAST = DIV_W'(CS_SETUP - 1);
    localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [4:0]         bit_q, bit_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               cs_n_q, cs_n_d;
    logic               sck_q, sck_d;
    logic [15:0]        cmd_q, cmd_d;
    logic [15:0]        rx_q, rx_d;
    logic               cur_chan_q, cur_chan_d;
    logic               pend_vld_q, pend_vld_d;
    logic               pend_chan_q, pend_chan_d;
    logic signed [15:0] data_q, data_d;
    logic               chan_q, chan_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;

    logic go, half_done, bits_done, tmr_exp;
    logic frame_start, frame_end, load, cmd_chan;

    function automatic logic [15:0] to_sample(input logic [15:0] raw);
`ifdef ADC_SIGN_CONVERT_EN
        return {~raw[15], raw[14:0]};
`else
        return raw;
`endif
    endfunction

    assign go        = enable && (chan_en != 2'b00);
    assign half_done = (div_q == HALF_LAST);
    // bit_q counts SCK falling edges; 16 means all bits have been clocked
    assign bits_done = (bit_q == 5'd16);
    assign tmr_exp   = (tmr_q == TMR_LAST);

    // State register
    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            tmr_q       <= '0;
            cs_n_q      <= 1'b1;
            sck_q       <= 1'b0;
            cmd_q       <= '0;
            rx_q        <= '0;
            cur_chan_q  <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_chan_q <= 1'b0;
            data_q      <= '0;
            chan_q      <= 1'b0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            tmr_q       <= tmr_d;
            cs_n_q      <= cs_n_d;
            sck_q       <= sck_d;
            cmd_q       <= cmd_d;
            rx_q        <= rx_d;
            cur_chan_q  <= cur_chan_d;
            pend_vld_q  <= pend_vld_d;
            pend_chan_q <= pend_chan_d;
            data_q      <= data_d;
            chan_q      <= chan_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = SETUP;
            SETUP:   if (div_q == SETUP_LAST) state_d = SHIFT;
            // the 16th low phase runs its full length before CS_ rises
            SHIFT:   if (!sck_q && half_done && bits_done) state_d = GAP;
            GAP:     if (tmr_exp) state_d = go ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next-value logic
    always_comb begin
        frame_start = (state_d == SETUP) && (state_q != SETUP);
        frame_end   = (state_q == SHIFT) && (state_d == GAP);
        load        = frame_end && pend_vld_q;

        // L/R alternation restarts at L on every session start
        case (chan_en)
            2'b10:   cmd_chan = 1'b1;
            2'b11:   cmd_chan = (state_q == IDLE) ? 1'b0 : ~cur_chan_q;
            default: cmd_chan = 1'b0;
        endcase

        div_d       = '0;
        bit_d       = bit_q;
        tmr_d       = tmr_q + TMR_W'(1);
        sck_d       = sck_q;
        cmd_d       = cmd_q;
        rx_d        = rx_q;
        cur_chan_d  = cur_chan_q;
        pend_vld_d  = pend_vld_q;
        pend_chan_d = pend_chan_q;
        data_d      = data_q;
        chan_d      = chan_q;
        valid_d     = valid_q;
        ovr_d       = ovr_q;
        cs_n_d      = (state_d == IDLE) || (state_d == GAP);

        if (frame_start || state_d == IDLE) tmr_d = '0;

        if (state_q == SETUP) begin
            if (div_q == SETUP_LAST) sck_d = 1'b1;
            else                     div_d = div_q + DIV_W'(1);
        end else if (state_q == SHIFT) begin
            if (!half_done)          div_d = div_q + DIV_W'(1);
            else if (!bits_done)     sck_d = ~sck_q;
        end

        // SDO is captured on the edge that raises SCK
        if (sck_d && !sck_q) rx_d = {rx_q[14:0], SDO};
        // SDI advances on the edge that lowers SCK
        if (sck_q && !sck_d) begin
            cmd_d = {cmd_q[14:0], 1'b0};
            bit_d = bit_q + 5'd1;
        end

        if (frame_start) begin
            cmd_d      = {1'b1, cmd_chan, 14'b0};
            bit_d      = '0;
            cur_chan_d = cmd_chan;
            if (state_q == IDLE) pend_vld_d = 1'b0;
        end

        if (frame_end) begin
            pend_vld_d  = 1'b1;
            pend_chan_d = cur_chan_q;
        end

        if (valid_q && sample_ready) valid_d = 1'b0;
        if (overrun_clr)             ovr_d   = 1'b0;
        if (load) begin
            data_d  = $signed(to_sample(rx_q));
            chan_d  = pend_chan_q;
            valid_d = 1'b1;
            if (valid_q && !sample_ready) ovr_d = 1'b1;
        end
    end

    assign CS_          = cs_n_q;
    assign SCK          = sck_q;
    assign SDI          = cmd_q[15];
    assign sample_data  = data_q;
    assign sample_chan  = chan_q;
    assign sample_valid = valid_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_adc_spi_controller.sv
// -----------------------------------------------------------------------------
// tb_adc_spi_controller
//
// Directed bench for adc_spi_controller with CLK_DIV=2, CS_SETUP=2,
// SAMPLE_PERIOD=100. A behavioural ADC model returns, in each frame, the next
// word from the table of the channel commanded in the previous frame
// (left: 4000, 4111, 4222...; right: E000, E111...), or DEAD when nothing was
// commanded yet.
// -----------------------------------------------------------------------------
module tb_adc_spi_controller;

    logic        CLK = 1'b0;
    logic        RESET_ = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  chan_en = 2'b00;
    logic        CS_, SCK, SDI;
    logic        SDO = 1'b0;
    logic [15:0] sample_data;
    logic        sample_chan, sample_valid;
    logic        sample_ready = 1'b1;
    logic        overrun;
    logic        overrun_clr = 1'b0;

    int n_chk = 0;
    int n_bad = 0;

    adc_spi_controller #(
        .CLK_DIV(2),
        .CS_SETUP(2),
        .SAMPLE_PERIOD(100)
    ) dut (
        .CLK(CLK),
        .RESET_(RESET_),
        .enable(enable),
        .chan_en(chan_en),
        .CS_(CS_),
        .SCK(SCK),
        .SDI(SDI),
        .SDO(SDO),
        .sample_data(sample_data),
        .sample_chan(sample_chan),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 CLK = ~CLK;

    // ---------------- ADC model ----------------
    logic [15:0] left_tab  [8] = '{16'h4000, 16'h4111, 16'h4222, 16'h4333,
                                   16'h4444, 16'h4555, 16'h4666, 16'h4777};
    logic [15:0] right_tab [8] = '{16'hE000, 16'hE111, 16'hE222, 16'hE333,
                                   16'hE444, 16'hE555, 16'hE666, 16'hE777};
    logic [2:0]  lidx = '0, ridx = '0;
    logic [15:0] adc_word = '0, adc_cmd = '0;
    logic        adc_pend = 1'b0, adc_pend_v = 1'b0;
    logic        m_cs = 1'b1, m_sck = 1'b0;
    int          adc_n = 0;
    logic [15:0] sdi_q[$];
    int          nsck_q[$];

    always @(negedge CLK) begin
        if (!RESET_) begin
            m_cs = 1'b1; m_sck = 1'b0; adc_pend_v = 1'b0;
            lidx = '0; ridx = '0; SDO = 1'b0;
            sdi_q.delete(); nsck_q.delete();
        end else begin
            if (!CS_ && m_cs) begin
                if (!adc_pend_v)   adc_word = 16'hDEAD;
                else if (!adc_pend) begin adc_word = left_tab[lidx];  lidx++; end
                else               begin adc_word = right_tab[ridx]; ridx++; end
                SDO = adc_word[15];
                adc_cmd = '0;
                adc_n = 0;
            end else if (!CS_ && SCK && !m_sck) begin
                adc_cmd = {adc_cmd[14:0], SDI};
                adc_n++;
            end else if (!CS_ && !SCK && m_sck) begin
                adc_word = {adc_word[14:0], 1'b0};
                SDO = adc_word[15];
            end
            if (CS_ && !m_cs) begin
                sdi_q.push_back(adc_cmd);
                nsck_q.push_back(adc_n);
                adc_pend = adc_cmd[14];
                adc_pend_v = 1'b1;
            end
            m_cs = CS_;
            m_sck = SCK;
        end
    end

    // ---------------- bus monitor ----------------
    int          cyc = 0, low_cnt = 0, rise_cnt = 0, fall_cnt = 0;
    logic        cs_prev = 1'b1;
    int          fall_t[$];
    int          low_q[$];
    logic [16:0] smp_q[$];

    always @(negedge CLK) begin
        if (!RESET_) begin
            cyc = 0; low_cnt = 0; rise_cnt = 0; fall_cnt = 0; cs_prev = 1'b1;
            fall_t.delete(); low_q.delete(); smp_q.delete();
        end else begin
            cyc++;
            if (!CS_) low_cnt++;
            if (!CS_ && cs_prev) begin fall_t.push_back(cyc); fall_cnt++; end
            if (CS_ && !cs_prev) begin low_q.push_back(low_cnt); low_cnt = 0; rise_cnt++; end
            if (sample_valid && sample_ready) smp_q.push_back({sample_chan, sample_data});
            cs_prev = CS_;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [15:0] exp_data(input logic [15:0] raw);
`ifdef ADC_SIGN_CONVERT_EN
        return {~raw[15], raw[14:0]};
`else
        return raw;
`endif
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        RESET_ = 1'b0; enable = 1'b0; chan_en = 2'b00;
        sample_ready = 1'b1; overrun_clr = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RESET_ = 1'b1;
    endtask

    task automatic wait_rises(input int n);
        int t = 0;
        while (rise_cnt < n && t < 2000) begin
            @(posedge CLK);
            t++;
        end
        if (rise_cnt < n) chk_eq("frame_timeout", rise_cnt, n);
    endtask

    task automatic wait_cs_low();
        int t = 0;
        @(negedge CLK);
        while (CS_ && t < 2000) begin
            @(negedge CLK);
            t++;
        end
        if (CS_) chk_eq("cs_fall_timeout", CS_, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        chk_eq("rst_cs", CS_, 1'b1);
        chk_eq("rst_sck", SCK, 1'b0);
        chk_eq("rst_sdi", SDI, 1'b0);
        chk_eq("rst_valid", sample_valid, 1'b0);
        chk_eq("rst_ovr", overrun, 1'b0);
        chk_eq("rst_data", sample_data, 16'h0000);

        // Stereo, always ready
        do_reset();
        chan_en = 2'b11; sample_ready = 1'b1; enable = 1'b1;
        wait_rises(3);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_eq("A_nsdi", sdi_q.size(), 3);
        chk_eq("A_sdi0", sdi_q[0], 16'h8000);
        chk_eq("A_sdi1", sdi_q[1], 16'hC000);
        chk_eq("A_sdi2", sdi_q[2], 16'h8000);
        chk_eq("A_nsck", nsck_q[1], 16);
        chk_eq("A_nsmp", smp_q.size(), 2);
        chk_eq("A_smp0", smp_q[0], {1'b0, exp_data(16'h4000)});
        chk_eq("A_smp1", smp_q[1], {1'b1, exp_data(16'hE000)});
        chk_eq("A_low0", low_q[0], 66);
        chk_eq("A_low2", low_q[2], 66);
        chk_eq("A_per1", fall_t[1] - fall_t[0], 100);
        chk_eq("A_per2", fall_t[2] - fall_t[1], 100);

        // Left only
        do_reset();
        chan_en = 2'b01; enable = 1'b1;
        wait_rises(3);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_eq("B_sdi0", sdi_q[0], 16'h8000);
        chk_eq("B_sdi1", sdi_q[1], 16'h8000);
        chk_eq("B_sdi2", sdi_q[2], 16'h8000);
        chk_eq("B_nsmp", smp_q.size(), 2);
        chk_eq("B_smp0", smp_q[0], {1'b0, exp_data(16'h4000)});
        chk_eq("B_smp1", smp_q[1], {1'b0, exp_data(16'h4111)});

        // Back-pressure and overrun
        do_reset();
        chan_en = 2'b11; sample_ready = 1'b0; enable = 1'b1;
        wait_rises(2);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_eq("C2_valid", sample_valid, 1'b1);
        chk_eq("C2_ovr", overrun, 1'b0);
        chk_eq("C2_data", sample_data, exp_data(16'h4000));
        // ready only in the load cycle of frame 3: old retires, no overrun
        wait_cs_low();
        repeat (65) @(posedge CLK);
        #1 sample_ready = 1'b1;
        @(posedge CLK);
        #1 sample_ready = 1'b0;
        @(negedge CLK);
        chk_eq("C3_valid", sample_valid, 1'b1);
        chk_eq("C3_ovr", overrun, 1'b0);
        chk_eq("C3_data", sample_data, exp_data(16'hE000));
        chk_eq("C3_chan", sample_chan, 1'b1);
        chk_eq("C3_retired", smp_q.size(), 1);
        chk_eq("C3_old", smp_q[0], {1'b0, exp_data(16'h4000)});
        // frame 4 overwrites the unaccepted E000
        wait_rises(4);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_eq("C4_valid", sample_valid, 1'b1);
        chk_eq("C4_ovr", overrun, 1'b1);
        chk_eq("C4_data", sample_data, exp_data(16'h4111));
        chk_eq("C4_chan", sample_chan, 1'b0);
        @(posedge CLK); #1 sample_ready = 1'b1;
        @(posedge CLK); #1 sample_ready = 1'b0;
        @(negedge CLK);
        chk_eq("C4_accept", sample_valid, 1'b0);
        chk_eq("C4_sticky", overrun, 1'b1);
        @(posedge CLK); #1 overrun_clr = 1'b1;
        @(posedge CLK); #1 overrun_clr = 1'b0;
        @(negedge CLK);
        chk_eq("C4_clr", overrun, 1'b0);
        wait_rises(5);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_eq("C5_ovr", overrun, 1'b0);
        chk_eq("C5_data", sample_data, exp_data(16'hE111));
        // clear coincides with an overwrite: set wins
        wait_cs_low();
        repeat (65) @(posedge CLK);
        #1 overrun_clr = 1'b1;
        @(posedge CLK);
        #1 overrun_clr = 1'b0;
        @(negedge CLK);
        chk_eq("C6_ovr_prio", overrun, 1'b1);
        chk_eq("C6_data", sample_data, exp_data(16'h4222));

        // Enable dropped during frame 3 SHIFT, then re-enabled
        do_reset();
        chan_en = 2'b11; sample_ready = 1'b1; enable = 1'b1;
        wait_rises(2);
        wait_cs_low();
        repeat (20) @(posedge CLK);
        #1 enable = 1'b0;
        wait_rises(3);
        repeat (150) @(posedge CLK);
        @(negedge CLK);
        chk_eq("D_falls", fall_cnt, 3);
        chk_eq("D_cs_idle", CS_, 1'b1);
        chk_eq("D_nsmp", smp_q.size(), 2);
        chk_eq("D_smp1", smp_q[1], {1'b1, exp_data(16'hE000)});
        @(posedge CLK);
        #1 enable = 1'b1;
        wait_rises(5);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_eq("D_sdi3", sdi_q[3], 16'h8000);
        chk_eq("D_sdi4", sdi_q[4], 16'hC000);
        chk_eq("D_nsmp2", smp_q.size(), 3);
        chk_eq("D_smp2", smp_q[2], {1'b0, exp_data(16'h4222)});

        // Asynchronous reset in the middle of SHIFT
        do_reset();
        chan_en = 2'b01; enable = 1'b1;
        wait_cs_low();
        repeat (6) @(posedge CLK);
        #2;
        chk_eq("E_pre_sck", SCK, 1'b1);
        chk_eq("E_pre_cs", CS_, 1'b0);
        RESET_ = 1'b0;
        #1;
        chk_eq("E_cs", CS_, 1'b1);
        chk_eq("E_sck", SCK, 1'b0);
        chk_eq("E_sdi", SDI, 1'b0);
        do_reset();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
